// File: rtl/ov7670_config_seq_pkg.sv
// ov7670_pkg: shared constants, table markers and sequencer state encodings.
package ov7670_pkg;
  localparam logic [7:0]  CAM_ID_WR   = 8'h42;
  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;
  typedef logic [2:0] state_t;
  localparam state_t PWRUP = 3'd0;
  localparam state_t FETCH = 3'd1;
  localparam state_t CHECK = 3'd2;
  localparam state_t SEND  = 3'd3;
  localparam state_t DELAY = 3'd4;
  localparam state_t DONE  = 3'd5;
endpackage

// File: rtl/ov7670_config_seq_if.sv
// ov7670_config_seq_if: request/accept link between the sequencer and the SCCB sender.
interface ov7670_config_seq_if;
  logic       send;
  logic [7:0] id;
  logic [7:0] reg_addr;
  logic [7:0] value;
  logic       taken;
  modport master (output send, id, reg_addr, value, input taken);
  modport slave  (input send, id, reg_addr, value, output taken);
endinterface

// File: rtl/ov7670_reg_rom.sv
// ov7670_reg_rom: combinational {reg_addr, value} table; anything past the list reads the end marker.
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic [IDX_W-1:0] addr,
  output logic [15:0]      dout
);
  always_comb begin
    case (addr)
      IDX_W'(0): dout = 16'h1280;
      IDX_W'(1): dout = ENTRY_DELAY;
      IDX_W'(2): dout = 16'h1204;
      IDX_W'(3): dout = 16'h40D0;
      IDX_W'(4): dout = ENTRY_END;
      default:   dout = ENTRY_END;
    endcase
  end
endmodule

// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq: walks the register table after power-up and hands each entry to the SCCB sender.
module ov7670_config_seq
  import ov7670_pkg::*;
#(
  parameter logic [7:0] CAM_ID    = CAM_ID_WR,
  parameter int         PWRUP_CYC = 1_250_000,
  parameter int         DELAY_CYC = 250_000,
  parameter int         IDX_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic resend,
  output logic config_done,
  ov7670_config_seq_if.master bus
);
  localparam int CNT_W = $clog2(PWRUP_CYC > DELAY_CYC ? PWRUP_CYC : DELAY_CYC) + 1;
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DELAY_CYC - 1);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      entry_q, entry_d, rom_dout;
  logic             send_q, send_d, done_q, done_d;
  logic [7:0]       addr_q, addr_d, val_q, val_d;
  ov7670_reg_rom #(.IDX_W(IDX_W)) u_rom (.addr(idx_q), .dout(rom_dout));
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    send_d  = send_q;
    addr_d  = addr_q;
    val_d   = val_q;
    done_d  = done_q;
    case (state_q)
      PWRUP: begin
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        state_d = cnt_q == '0 ? FETCH : PWRUP;
      end
      FETCH: begin
        entry_d = rom_dout;
        state_d = CHECK;
      end
      CHECK: begin
        if (entry_q == ENTRY_END) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (entry_q == ENTRY_DELAY) begin
          cnt_d   = DLY_LOAD;
          state_d = DELAY;
        end else begin
          addr_d  = entry_q[15:8];
          val_d   = entry_q[7:0];
          send_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.taken) begin
          send_d  = 1'b0;
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end
      end
      DELAY: begin
        if (cnt_q == '0) begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (resend) begin
          idx_d   = '0;
          done_d  = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = PWRUP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PWRUP;
      idx_q   <= '0;
      cnt_q   <= PWR_LOAD;
      entry_q <= '0;
      send_q  <= 1'b0;
      addr_q  <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      send_q  <= send_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end
  assign bus.send     = send_q;
  assign bus.id       = CAM_ID;
  assign bus.reg_addr = addr_q;
  assign bus.value    = val_q;
  assign config_done  = done_q;
endmodule

// File: tb/tb_ov7670_config_seq.sv
// tb_ov7670_config_seq: directed walk through power-up, handshake, delay, done, resend and reset.
module tb_ov7670_config_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resend = 1'b0;
  logic config_done;
  logic bad;
  int   checks = 0;
  int   errors = 0;
  int   n;
  ov7670_config_seq_if bus();
  ov7670_config_seq #(.PWRUP_CYC(16), .DELAY_CYC(8)) dut (
    .clk(clk), .rst(rst), .resend(resend), .config_done(config_done), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_send();
    n = 0;
    while (bus.send !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask
  initial begin
    bus.taken = 1'b0;
    repeat (3) tick();
    chk("rst_send", bus.send, 0);
    chk("rst_id", bus.id, 8'h42);
    chk("rst_addr", bus.reg_addr, 8'h00);
    chk("rst_value", bus.value, 8'h00);
    chk("rst_done", config_done, 0);
    rst = 1'b0;
    wait_send();
    chk("pwrup_latency", n, 18);
    chk("first_addr", bus.reg_addr, 8'h12);
    chk("first_value", bus.value, 8'h80);
    chk("first_id", bus.id, 8'h42);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      resend = (i == 50);
      tick();
      if (bus.send !== 1'b1 || bus.reg_addr !== 8'h12 || bus.value !== 8'h80) bad = 1'b1;
    end
    resend = 1'b0;
    chk("hold_stable", bad, 0);
    bus.taken = 1'b1;
    tick();
    bus.taken = 1'b0;
    chk("send_drop", bus.send, 0);
    chk("hold_after", bus.reg_addr, 8'h12);
    wait_send();
    chk("delay_gap", n, 12);
    chk("e2_addr", bus.reg_addr, 8'h12);
    chk("e2_value", bus.value, 8'h04);
    bus.taken = 1'b1;
    tick();
    bus.taken = 1'b0;
    wait_send();
    chk("write_gap", n, 2);
    chk("e3_addr", bus.reg_addr, 8'h40);
    chk("e3_value", bus.value, 8'hD0);
    bus.taken = 1'b1;
    tick();
    bus.taken = 1'b0;
    n = 0;
    while (config_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("done_latency", n, 2);
    chk("done_send", bus.send, 0);
    bus.taken = 1'b1;
    repeat (3) tick();
    bus.taken = 1'b0;
    tick();
    chk("done_held", config_done, 1);
    chk("done_no_send", bus.send, 0);
    chk("done_hold_addr", bus.reg_addr, 8'h40);
    chk("done_hold_value", bus.value, 8'hD0);
    resend = 1'b1;
    tick();
    resend = 1'b0;
    chk("resend_done_fall", config_done, 0);
    wait_send();
    chk("resend_latency", n, 2);
    chk("resend_addr", bus.reg_addr, 8'h12);
    chk("resend_value", bus.value, 8'h80);
    rst = 1'b1;
    tick();
    chk("midrst_send", bus.send, 0);
    chk("midrst_done", config_done, 0);
    chk("midrst_addr", bus.reg_addr, 8'h00);
    rst = 1'b0;
    wait_send();
    chk("midrst_pwrup", n, 18);
    chk("midrst_first", bus.reg_addr, 8'h12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
